// File: rtl/fp_mul_sched.sv
// Time-shared controller for one external combinational FP multiplier:
// round-robin request arbitration, fixed-latency execution, valid/ready result return.
module fp_mul_sched #(
    parameter int NREQ    = 2,
    parameter int MUL_LAT = 1,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_dataA,
    input  logic [32*NREQ-1:0]   req_dataB,
    output logic [31:0]          mul_dataA,
    output logic [31:0]          mul_dataB,
    input  logic [31:0]          mul_dataR,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_nan,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic            grant_any;
    logic [CW-1:0]   exec_cnt;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % 32'(NREQ));
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_any && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    if (exec_cnt == '0) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            exec_cnt  <= '0;
            mul_dataA <= '0;
            mul_dataB <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_nan   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        mul_dataA <= req_dataA[32*int'(grant_idx) +: 32];
                        mul_dataB <= req_dataB[32*int'(grant_idx) +: 32];
                        rsp_id    <= grant_idx;
                        rr_ptr    <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                        exec_cnt  <= CW'(MUL_LAT-1);
                    end
                end
                EXEC: begin
                    if (exec_cnt == '0) begin
                        rsp_data <= mul_dataR;
                        rsp_nan  <= (mul_dataR[30:23] == 8'hFF) && (mul_dataR[22:0] != '0);
                    end else begin
                        exec_cnt <= exec_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) op_count <= op_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp_mul_sched.sv
// Self-checking bench for fp_mul_sched: scoreboarded responses, vector table for
// arbitration, directed sequences for back-pressure, latency, reset and NaN/wrap.
module tb_fp_mul_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [63:0] req_dataA, req_dataB;
    logic [31:0] mul_dataA, mul_dataB, mul_dataR;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [0:0]  rsp_id;
    logic        rsp_nan, busy;
    logic [15:0] op_count;

    logic [1:0]  req_valid3, req_ready3;
    logic [63:0] req_dataA3, req_dataB3;
    logic [31:0] mul_dataA3, mul_dataB3, mul_dataR3;
    logic        rsp_valid3, rsp_ready3;
    logic [31:0] rsp_data3;
    logic [0:0]  rsp_id3;
    logic        rsp_nan3, busy3;
    logic [15:0] op_count3;

    logic        ovr_en;
    logic [31:0] ovr_val;
    logic [31:0] r3;

    // Ideal multiplier for normal operands (exact products only), zero passthrough.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:0] == '0 || b[30:0] == '0) return {s, 31'b0};
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            return {s, e[7:0], p[46:24]};
        end
        return {s, e[7:0], p[45:23]};
    endfunction

    assign mul_dataR  = ovr_en ? ovr_val : fmul(mul_dataA, mul_dataB);
    assign mul_dataR3 = r3;

    fp_mul_sched #(.NREQ(2), .MUL_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dataA(req_dataA), .req_dataB(req_dataB),
        .mul_dataA(mul_dataA), .mul_dataB(mul_dataB), .mul_dataR(mul_dataR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_nan(rsp_nan),
        .busy(busy), .op_count(op_count)
    );

    fp_mul_sched #(.NREQ(2), .MUL_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_dataA(req_dataA3), .req_dataB(req_dataB3),
        .mul_dataA(mul_dataA3), .mul_dataB(mul_dataB3), .mul_dataR(mul_dataR3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_id(rsp_id3), .rsp_nan(rsp_nan3),
        .busy(busy3), .op_count(op_count3)
    );

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        n;
    } vec_t;

    typedef struct {
        logic [0:0]  id;
        logic [31:0] data;
        logic        nan;
    } exp_t;

    vec_t        tbl [6];
    exp_t        sb [$];
    logic [31:0] exp_r [2];
    logic        exp_n [2];
    int          tests = 0;
    int          fails = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = 1'(i);
                    e.data = exp_r[i];
                    e.nan  = exp_n[i];
                    sb.push_back(e);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got id %0d data %h, required no response", rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    check32("rsp_data", rsp_data, e.data);
                    check32("rsp_id", 32'(rsp_id), 32'(e.id));
                    check32("rsp_nan", 32'(rsp_nan), 32'(e.nan));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input logic n);
        req_dataA[id*32 +: 32] = a;
        req_dataB[id*32 +: 32] = b;
        exp_r[id]     = r;
        exp_n[id]     = n;
        req_valid[id] = 1'b1;
    endtask

    task automatic drive_vec(input vec_t v);
        drive_op(v.id, v.a, v.b, v.r, v.n);
    endtask

    task automatic wait_grant(input int id, input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        check32(name, 32'(req_ready), oh(id));
    endtask

    task automatic drain(input string name);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                idle = 1'b1;
                break;
            end
        end
        check32(name, 32'(idle), 32'd1);
        step();
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check32(name, 32'(rsp_valid), 32'd1);
    endtask

    logic [31:0] nan_in [3];
    logic        nan_exp [3];
    int          k;

    initial begin
        tbl[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0};
        tbl[1] = '{1, 32'h40400000, 32'h3FC00000, 32'h40900000, 1'b0};
        tbl[2] = '{0, 32'hC0000000, 32'h40200000, 32'hC0A00000, 1'b0};
        tbl[3] = '{1, 32'h00000000, 32'h40A00000, 32'h00000000, 1'b0};
        tbl[4] = '{0, 32'h40800000, 32'h3F000000, 32'h40000000, 1'b0};
        tbl[5] = '{1, 32'hBF800000, 32'hBF800000, 32'h3F800000, 1'b0};
        nan_in[0] = 32'h7FC00000; nan_exp[0] = 1'b1;
        nan_in[1] = 32'h7F800000; nan_exp[1] = 1'b0;
        nan_in[2] = 32'h7F800001; nan_exp[2] = 1'b1;

        rst = 1'b1; req_valid = '0; req_dataA = '0; req_dataB = '0; rsp_ready = 1'b1;
        ovr_en = 1'b0; ovr_val = '0;
        req_valid3 = '0; req_dataA3 = '0; req_dataB3 = '0; rsp_ready3 = 1'b1; r3 = '0;
        repeat (2) step();
        @(negedge clk);
        check32("rst_rsp_valid", 32'(rsp_valid), 0);
        check32("rst_busy", 32'(busy), 0);
        check32("rst_op_count", 32'(op_count), 0);
        check32("rst_mul_dataA", mul_dataA, 0);
        check32("rst_req_ready", 32'(req_ready), 0);
        step();
        rst = 1'b0;

        // Single operation, MUL_LAT=1
        drive_vec(tbl[0]);
        wait_grant(0, "a_grant");
        step();
        req_valid = '0;
        @(negedge clk);
        check32("a_busy", 32'(busy), 1);
        check32("a_valid_early", 32'(rsp_valid), 0);
        check32("a_mul_dataA", mul_dataA, 32'h3F800000);
        @(negedge clk);
        check32("a_rsp_valid", 32'(rsp_valid), 1);
        @(negedge clk);
        check32("a_op_count", 32'(op_count), 1);
        check32("a_idle", 32'(busy), 0);
        step();

        // Alternating grants with both requesters always valid
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        drive_vec(tbl[0]);
        drive_vec(tbl[1]);
        k = 0;
        for (int cyc = 0; cyc < 100 && k < 6; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check32($sformatf("b_grant%0d", k), 32'(req_ready), oh(tbl[k].id));
                step();
                if (k + 2 < 6) drive_vec(tbl[k+2]);
                else req_valid[tbl[k].id] = 1'b0;
                k++;
            end else begin
                step();
            end
        end
        check32("b_grants", k, 6);
        req_valid = '0;
        drain("b_drain");
        check32("b_op_count", 32'(op_count), 6);

        // Back-pressure in DONE
        rsp_ready = 1'b0;
        drive_vec(tbl[0]);
        wait_grant(0, "c_grant");
        step();
        req_valid = '0;
        wait_rsp("c_rsp_wait");
        step();
        drive_vec(tbl[1]);
        drive_vec(tbl[2]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("c_hold_valid", 32'(rsp_valid), 1);
            check32("c_hold_data", rsp_data, 32'h40000000);
            check32("c_hold_id", 32'(rsp_id), 0);
            check32("c_hold_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check32("c_next_grant", 32'(req_ready), 32'b10);
        step();
        req_valid = '0;
        drain("c_drain");

        // MUL_LAT=3: only the value in the third EXEC cycle is captured
        req_dataA3[31:0] = 32'h40400000;
        req_dataB3[31:0] = 32'h3FC00000;
        req_valid3 = 2'b01;
        @(negedge clk);
        check32("d_grant", 32'(req_ready3), 32'b01);
        step();
        req_valid3 = '0;
        r3 = 32'hAAAA0001;
        @(negedge clk);
        check32("d_valid_c1", 32'(rsp_valid3), 0);
        step();
        r3 = 32'hBBBB0002;
        @(negedge clk);
        check32("d_valid_c2", 32'(rsp_valid3), 0);
        step();
        r3 = 32'hCCCC0003;
        @(negedge clk);
        check32("d_valid_c3", 32'(rsp_valid3), 0);
        check32("d_busy", 32'(busy3), 1);
        step();
        r3 = 32'hDDDD0004;
        @(negedge clk);
        check32("d_rsp_valid", 32'(rsp_valid3), 1);
        check32("d_rsp_data", rsp_data3, 32'hCCCC0003);
        check32("d_mul_dataA", mul_dataA3, 32'h40400000);
        step();
        @(negedge clk);
        check32("d_op_count", 32'(op_count3), 1);
        step();

        // Reset during EXEC
        rsp_ready = 1'b0;
        drive_vec(tbl[0]);
        wait_grant(0, "e_grant1");
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check32("e1_rsp_valid", 32'(rsp_valid), 0);
        check32("e1_busy", 32'(busy), 0);
        check32("e1_op_count", 32'(op_count), 0);
        check32("e1_mul_dataA", mul_dataA, 0);
        step();

        // Reset during DONE, then tie-break must favour requester 0
        drive_vec(tbl[2]);
        wait_grant(0, "e_grant2");
        step();
        req_valid = '0;
        wait_rsp("e_rsp_wait");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check32("e2_rsp_valid", 32'(rsp_valid), 0);
        check32("e2_busy", 32'(busy), 0);
        check32("e2_mul_dataA", mul_dataA, 0);
        check32("e2_rsp_data", rsp_data, 0);
        step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("e2_no_rsp", 32'(rsp_valid), 0);
            step();
        end
        drive_vec(tbl[4]);
        drive_vec(tbl[5]);
        @(negedge clk);
        check32("e_tie", 32'(req_ready), 32'b01);
        step();
        req_valid = '0;
        drain("e_drain");

        // NaN flag on the result, including the infinity boundary
        ovr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ovr_val = nan_in[i];
            drive_op(i % 2, 32'h3F800000, 32'h3F800000, nan_in[i], nan_exp[i]);
            wait_grant(i % 2, $sformatf("f_grant%0d", i));
            step();
            req_valid = '0;
            drain($sformatf("f_drain%0d", i));
        end
        ovr_en = 1'b0;

        // op_count wrap
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        @(negedge clk);
        check32("g_preload", 32'(op_count), 32'hFFFF);
        step();
        drive_vec(tbl[0]);
        wait_grant(0, "g_grant");
        step();
        req_valid = '0;
        drain("g_drain");
        check32("g_wrap", 32'(op_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mul_sched.md
Name: fp_mul_sched

Overview:
- Time-shared controller for one combinational single-precision multiplier unit (dataA, dataB -> dataR).
- Round-robin arbitrates NREQ requesters and registers the winning operands onto the multiplier inputs.
- Waits MUL_LAT cycles for the datapath to settle, captures the product and returns it with the requester ID over a valid/ready response channel.
- One operation in flight at a time; the multiplier is instantiated beside this block, not inside it.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MUL_LAT, 1, cycles operands are held before dataR is sampled (>=1); covers the multiplier's combinational path.
- IDW, $clog2(NREQ) (min 1), width of the requester ID.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  one-hot grant; handshake when valid & ready.
- req_dataA  in  32*NREQ  operand A, slice i = [32i+31:32i], IEEE-754 single.
- req_dataB  in  32*NREQ  operand B, same packing.
- mul_dataA  out  32  registered operand A to the multiplier.
- mul_dataB  out  32  registered operand B to the multiplier.
- mul_dataR  in  32  multiplier result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  32  captured product.
- rsp_id  out  IDW  index of the requester that issued the operation.
- rsp_nan  out  1  rsp_data[30:23]==8'hFF and rsp_data[22:0]!=0.
- busy  out  1  high in EXEC or DONE.
- op_count  out  16  completed responses; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (rst high at clk edge): state=IDLE, rr_ptr=0, exec counter=0.
  - mul_dataA, mul_dataB, rsp_data, rsp_id, op_count cleared to 0.
  - rsp_valid=0, rsp_nan=0, busy=0, req_ready=0.
  - Reset overrides everything, including an operation in EXEC or DONE; that operation is silently dropped.
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_ready is combinational: one-hot on the first requester with req_valid set, searching rr_ptr, rr_ptr+1, ... mod NREQ. All zeros if no request.
  - On handshake with requester g: mul_dataA/B <= slices g, rsp_id <= g, rr_ptr <= (g+1) mod NREQ, counter <= MUL_LAT-1, go to EXEC.
- EXEC:
  - req_ready=0; mul_dataA/B held stable.
  - If counter==0: rsp_data <= mul_dataR, rsp_nan computed from mul_dataR, go to DONE. Otherwise counter decrements.
  - EXEC therefore lasts exactly MUL_LAT cycles.
- DONE:
  - rsp_valid=1; rsp_data, rsp_id, rsp_nan and mul_dataA/B held stable; req_ready=0.
  - On rsp_ready: op_count increments, go to IDLE.
  - No grant is issued in the handshake cycle.
- Latency: grant at edge E -> rsp_valid high after edge E+MUL_LAT. Minimum issue interval is MUL_LAT+2 cycles with rsp_ready tied high.
- rsp_ready is ignored outside DONE. req_valid with no grant is not latched; a requester must hold valid until ready.
- rr_ptr only advances on a grant, so a lone requester is served back-to-back.
- Operand values are passed through unmodified: zero, infinity and NaN inputs are forwarded untouched. Special-case handling belongs to the multiplier.
- busy == (state != IDLE).

Test Plan:
- NREQ=2, MUL_LAT=1, multiplier modelled ideally; req0: A=3F800000, B=40000000 -> one-cycle req_ready[0]; rsp_valid two cycles after request; rsp_data=40000000, rsp_id=0, rsp_nan=0, op_count=1.
- Both requesters valid continuously, rsp_ready=1, six operations -> grants alternate 0,1,0,1,0,1; each rsp_id matches its grant; op_count=6.
- Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 0 despite req_valid; on rsp_ready=1 returns to IDLE, next grant in the following cycle.
- MUL_LAT=3; change mul_dataR model mid-EXEC -> value sampled only in the 3rd EXEC cycle is returned; rsp_valid exactly 3 cycles after grant edge.
- Assert rst in EXEC and again in DONE -> next edge: rsp_valid=0, busy=0, op_count=0, mul_dataA=0; pending operation never responds; rr_ptr=0 (req0 wins a tie).
- Multiplier returns 7FC00000 -> rsp_nan=1; preload op_count to FFFF via 65535 operations (or force), one more -> 0000.
